// File: rtl/instr_realigner.sv
// instr_realigner: halfword realignment buffer between fetch and decode.
// Fetch words are split into halfwords and queued in a small circular buffer;
// one RV32 or RVC instruction per cycle is extracted from the buffer head,
// including 32-bit instructions whose halves straddle two fetch words.
module instr_realigner #(
    parameter int unsigned HW_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_pc_i,
    input  logic [31:0] fetch_data_i,
    input  logic        fetch_err_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] id_pc_o,
    output logic        is_rv16_o,
    output logic        instr_err_o
);

    localparam int unsigned PTR_W = $clog2(HW_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // One buffered halfword with the PC it was fetched from and its fault bit.
    typedef struct packed {
        logic [15:0] data;
        logic [31:0] pc;
        logic        err;
    } hw_entry_t;

    // Reject depths the pointer arithmetic cannot wrap cleanly.
    if ((HW_DEPTH < 4) || ((HW_DEPTH & (HW_DEPTH - 1)) != 0)) begin : g_param_check
        $error("instr_realigner: HW_DEPTH must be a power of two and at least 4");
    end

    hw_entry_t              hw_buf_q [HW_DEPTH];
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [CNT_W-1:0]       cnt_q;

    logic [PTR_W-1:0]       rd_nxt1;
    logic [PTR_W-1:0]       wr_nxt1;
    hw_entry_t              h0;
    logic [15:0]            h1_data;
    logic                   h1_err;
    logic                   h0_rvc;
    logic                   h0_single;
    logic                   avail;
    logic                   do_push;
    logic                   do_pop;
    logic [1:0]             push_n;
    logic [1:0]             pop_n;

    // Head and head+1 view of the buffer.
    always_comb begin
        rd_nxt1   = rd_ptr_q + PTR_W'(1);
        wr_nxt1   = wr_ptr_q + PTR_W'(1);
        h0        = hw_buf_q[rd_ptr_q];
        h1_data   = hw_buf_q[rd_nxt1].data;
        h1_err    = hw_buf_q[rd_nxt1].err;
        h0_rvc    = (h0.data[1:0] != 2'b11);
        // A faulted head halfword is emitted alone; its partner may never arrive.
        h0_single = h0_rvc || h0.err;
        avail     = h0_single ? (cnt_q != CNT_W'(0)) : (cnt_q >= CNT_W'(2));
    end

    // Fetch-side acceptance; space is judged on the current fill level only.
    always_comb begin
        fetch_ready_o = !flush_i && (cnt_q <= CNT_W'(HW_DEPTH - 2));
        do_push       = fetch_valid_i && fetch_ready_o;
        push_n        = 2'd0;
        if (do_push) begin
            push_n = fetch_pc_i[1] ? 2'd1 : 2'd2;
        end
    end

    // Instruction extraction from the buffer head; outputs are zero when idle.
    always_comb begin
        instr_valid_o = 1'b0;
        instr_o       = 32'h0;
        id_pc_o       = 32'h0;
        is_rv16_o     = 1'b0;
        instr_err_o   = 1'b0;
        if (!flush_i && avail) begin
            instr_valid_o = 1'b1;
            id_pc_o       = h0.pc;
            if (h0_single) begin
                instr_o     = {16'h0, h0.data};
                is_rv16_o   = h0_rvc;
                instr_err_o = h0.err;
            end else begin
                instr_o     = {h1_data, h0.data};
                is_rv16_o   = 1'b0;
                instr_err_o = h1_err;
            end
        end
    end

    // Decoder-side consumption.
    always_comb begin
        do_pop = instr_valid_o && instr_ready_i;
        pop_n  = 2'd0;
        if (do_pop) begin
            pop_n = h0_single ? 2'd1 : 2'd2;
        end
    end

    // Pointer and fill-level update; flush empties the buffer in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= wr_ptr_q;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
            wr_ptr_q <= wr_ptr_q + PTR_W'(push_n);
            cnt_q    <= cnt_q + CNT_W'(push_n) - CNT_W'(pop_n);
        end
    end

    // Halfword storage; an unaligned fetch PC contributes only the upper half.
    always_ff @(posedge clk) begin
        if (do_push) begin
            if (fetch_pc_i[1]) begin
                hw_buf_q[wr_ptr_q] <= '{data: fetch_data_i[31:16], pc: fetch_pc_i, err: fetch_err_i};
            end else begin
                hw_buf_q[wr_ptr_q] <= '{data: fetch_data_i[15:0], pc: fetch_pc_i, err: fetch_err_i};
                hw_buf_q[wr_nxt1]  <= '{data: fetch_data_i[31:16], pc: fetch_pc_i + 32'd2,
                                        err: fetch_err_i};
            end
        end
    end

    // The fill level can never exceed the buffer depth.
    a_no_overflow: assert property (@(posedge clk) disable iff (rst) cnt_q <= CNT_W'(HW_DEPTH));

endmodule

// File: tb/tb_instr_realigner.sv
// Randomized scoreboard bench for instr_realigner with a halfword-queue model.
module tb_instr_realigner;

    localparam int unsigned D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        fetch_valid_i;
    logic        fetch_ready_o;
    logic [31:0] fetch_pc_i;
    logic [31:0] fetch_data_i;
    logic        fetch_err_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] id_pc_o;
    logic        is_rv16_o;
    logic        instr_err_o;

    instr_realigner #(.HW_DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush_i),
        .fetch_valid_i (fetch_valid_i),
        .fetch_ready_o (fetch_ready_o),
        .fetch_pc_i    (fetch_pc_i),
        .fetch_data_i  (fetch_data_i),
        .fetch_err_i   (fetch_err_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .id_pc_o       (id_pc_o),
        .is_rv16_o     (is_rv16_o),
        .instr_err_o   (instr_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic [31:0] pc;
        logic        e;
    } hw_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rv16;
        logic        err;
        int          sz;
    } ins_t;

    hw_t  pend_q [$];   // halfwords not yet forming a complete instruction
    ins_t exp_q  [$];   // complete instructions awaiting consumption
    int   mcnt;         // halfwords held by the design
    int   pop_sz;       // halfwords consumed at the coming edge
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Turn buffered halfwords into whole instructions by the RISC-V length rule.
    task automatic model_extract();
        hw_t h0, h1;
        while (pend_q.size() > 0) begin
            h0 = pend_q[0];
            if (h0.d[1:0] != 2'b11 || h0.e) begin
                exp_q.push_back('{{16'h0, h0.d}, h0.pc, (h0.d[1:0] != 2'b11), h0.e, 1});
                void'(pend_q.pop_front());
            end else if (pend_q.size() >= 2) begin
                h1 = pend_q[1];
                exp_q.push_back('{{h1.d, h0.d}, h0.pc, 1'b0, h0.e | h1.e, 2});
                void'(pend_q.pop_front());
                void'(pend_q.pop_front());
            end else begin
                break;
            end
        end
    endtask

    // Reference model: applies pushes, pops and flushes at each clock edge.
    initial begin
        mcnt   = 0;
        pop_sz = 0;
        forever begin
            @(posedge clk);
            if (rst || flush_i) begin
                pend_q.delete();
                exp_q.delete();
                mcnt = 0;
            end else begin
                mcnt = mcnt - pop_sz;
                if (fetch_valid_i && (mcnt + pop_sz) <= int'(D) - 2) begin
                    if (fetch_pc_i[1]) begin
                        pend_q.push_back('{fetch_data_i[31:16], fetch_pc_i, fetch_err_i});
                        mcnt = mcnt + 1;
                    end else begin
                        pend_q.push_back('{fetch_data_i[15:0], fetch_pc_i, fetch_err_i});
                        pend_q.push_back('{fetch_data_i[31:16], fetch_pc_i + 32'd2, fetch_err_i});
                        mcnt = mcnt + 2;
                    end
                end
                model_extract();
            end
        end
    end

    // Monitor: compares the presented instruction and handshake signals mid-cycle.
    initial begin
        logic exp_v;
        logic exp_rdy;
        ins_t e;
        forever begin
            @(negedge clk);
            pop_sz = 0;
            if (!rst) begin
                exp_v   = !flush_i && (exp_q.size() > 0);
                exp_rdy = !flush_i && (mcnt <= int'(D) - 2);
                chk("instr_valid", 64'(instr_valid_o), 64'(exp_v));
                chk("fetch_ready", 64'(fetch_ready_o), 64'(exp_rdy));
                if (instr_valid_o && exp_v) begin
                    e = exp_q[0];
                    chk("instr", 64'(instr_o), 64'(e.instr));
                    chk("id_pc", 64'(id_pc_o), 64'(e.pc));
                    chk("is_rv16", 64'(is_rv16_o), 64'(e.rv16));
                    chk("instr_err", 64'(instr_err_o), 64'(e.err));
                    if (instr_ready_i) begin
                        pop_sz = e.sz;
                        void'(exp_q.pop_front());
                    end
                end else if (!instr_valid_o) begin
                    chk("idle_zero", 64'({instr_o, id_pc_o, is_rv16_o, instr_err_o}), 64'(0));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one fetch word and hold it until accepted (bounded).
    task automatic push_word(input logic [31:0] pc, input logic [31:0] data, input logic err);
        logic ok;
        ok            = 1'b0;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = pc;
        fetch_data_i  = data;
        fetch_err_i   = err;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            ok = fetch_ready_o;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) begin
            failures++;
            $display("FAIL push_timeout: word at pc %h never accepted", pc);
        end
        fetch_valid_i = 1'b0;
        fetch_err_i   = 1'b0;
    endtask

    function automatic logic [15:0] rand_hw();
        logic [15:0] h;
        h = 16'($urandom);
        if ($urandom_range(0, 1) == 0) h[1:0] = 2'b11;
        return h;
    endfunction

    // Stimulus: directed scenarios, then randomized traffic, then drain.
    initial begin
        logic        acc;
        logic [31:0] pc;
        rst           = 1'b1;
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        fetch_pc_i    = 32'h0;
        fetch_data_i  = 32'h0;
        fetch_err_i   = 1'b0;
        instr_ready_i = 1'b0;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", 64'(instr_valid_o), 64'(0));
        chk("rst_fetch_ready", 64'(fetch_ready_o), 64'(1));
        chk("rst_outputs", 64'({instr_o, id_pc_o, is_rv16_o, instr_err_o}), 64'(0));
        idle(1);

        // Two RVC in one word.
        instr_ready_i = 1'b1;
        push_word(32'h8000_0000, 32'h0001_4501, 1'b0);
        idle(4);

        // 32-bit instruction straddling two fetch words.
        push_word(32'h8000_0000, 32'h0093_4505, 1'b0);
        push_word(32'h8000_0004, 32'h4501_0010, 1'b0);
        idle(4);

        // Unaligned fetch PC: upper halfword only.
        push_word(32'h8000_0002, 32'h1234_4505, 1'b0);
        idle(3);

        // Back-pressure: fill to three halfwords and stall the decoder.
        instr_ready_i = 1'b0;
        push_word(32'h8000_0102, 32'h0093_0000, 1'b0);
        push_word(32'h8000_0104, 32'h0093_0010, 1'b0);
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h8000_0108;
        fetch_data_i  = 32'h0093_0010;
        idle(6);
        instr_ready_i = 1'b1;
        push_word(32'h8000_0108, 32'h0093_0010, 1'b0);
        push_word(32'h8000_010C, 32'h4501_0010, 1'b0);
        idle(5);

        // Faulted fetch word of all ones.
        push_word(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        idle(4);

        // Flush with three halfwords buffered and a word on offer.
        instr_ready_i = 1'b0;
        push_word(32'h8000_0200, 32'h4505_4501, 1'b0);
        push_word(32'h8000_0206, 32'h4509_0000, 1'b0);
        flush_i       = 1'b1;
        fetch_valid_i = 1'b1;
        fetch_pc_i    = 32'h8000_0208;
        fetch_data_i  = 32'h4501_4501;
        idle(1);
        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        @(negedge clk);
        chk("flush_empty_ready", 64'(fetch_ready_o), 64'(1));
        chk("flush_empty_valid", 64'(instr_valid_o), 64'(0));
        idle(1);
        instr_ready_i = 1'b1;
        push_word(32'h8000_1000, 32'h0001_4501, 1'b0);
        idle(4);

        // Randomized traffic with back-pressure, faults and redirects.
        pc = 32'h8000_2000;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            acc = fetch_valid_i && fetch_ready_o;
            @(posedge clk);
            #1;
            if (acc) pc = {pc[31:2], 2'b00} + 32'd4;
            flush_i = ($urandom_range(0, 99) < 3);
            if (flush_i) pc = 32'h8000_0000 | ($urandom & 32'h0000_FFFE);
            fetch_valid_i = ($urandom_range(0, 3) != 0);
            fetch_pc_i    = pc;
            fetch_data_i  = {rand_hw(), rand_hw()};
            fetch_err_i   = ($urandom_range(0, 19) == 0);
            instr_ready_i = ($urandom_range(0, 3) != 0);
        end

        flush_i       = 1'b0;
        fetch_valid_i = 1'b0;
        instr_ready_i = 1'b1;
        idle(10);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
